// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand widths and the iteration-counter width helper.
package div_pkg;

    localparam int DIV_N = 8;
    localparam int DIV_M = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter must be able to hold the iteration count 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adder.sv
// Team parameterised ripple adder; used here as the divider's trial subtractor
// by feeding the inverted divisor with a carry-in of one.
module Adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/div8x4_cu.sv
// Divider control unit: IDLE/CALC/DONE sequencer, iteration counter and the
// strobes that drive the datapath, plus registered busy/done.
module div8x4_cu
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic b_zero,
    input  logic trial_ok,
    output logic ld_op,
    output logic shift_en,
    output logic sel_restore,
    output logic busy,
    output logic done
);

    localparam int CW = cnt_width(N);

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic          last_s;
    logic          busy_r;
    logic          done_r;

    assign last_s = (cnt_r == CW'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Iteration counter, cleared on each accepted operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (ld_op) begin
            cnt_r <= {CW{1'b0}};
        end else if (shift_en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // busy/done registered from the next state so they line up with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= (state_s == DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = b_zero ? DONE : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state.
    always_comb begin
        ld_op       = 1'b0;
        shift_en    = 1'b0;
        sel_restore = 1'b0;
        case (state_r)
            IDLE: ld_op = start;
            CALC: begin
                shift_en    = 1'b1;
                sel_restore = ~trial_ok;
            end
            DONE:    ld_op = 1'b0;
            default: ld_op = 1'b0;
        endcase
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: rtl/div8x4_dp.sv
// Divider datapath: quotient shift register, partial remainder, divisor
// register, trial subtractor and restore mux.
module div8x4_dp
    import div_pkg::*;
#(
    parameter int N = DIV_N,
    parameter int M = DIV_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_op,
    input  logic         shift_en,
    input  logic         sel_restore,
    input  logic [N-1:0] A,
    input  logic [M-1:0] B,
    output logic         b_zero,
    output logic         trial_ok,
    output logic [N-1:0] Q,
    output logic [M-1:0] R,
    output logic         dbz
);

    logic [N-1:0] q_r;
    logic [M:0]   p_r;
    logic [M-1:0] d_r;
    logic         dbz_r;
    logic [M:0]   p_shift_s;
    logic [M:0]   diff_s;
    logic         no_borrow_s;

    assign b_zero    = (B == {M{1'b0}});
    assign p_shift_s = {p_r[M-1:0], q_r[N-1]};

    Adder #(.W(M + 1)) u_trial (
        .a  (p_shift_s),
        .b  (~{1'b0, d_r}),
        .ci (1'b1),
        .s  (diff_s),
        .co (no_borrow_s)
    );

    // A bit shifted out of P's top means the trial value already exceeds any divisor.
    assign trial_ok = no_borrow_s | p_r[M];

    // Operand capture and one restoring iteration per enabled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r   <= {N{1'b0}};
            p_r   <= {(M + 1){1'b0}};
            d_r   <= {M{1'b0}};
            dbz_r <= 1'b0;
        end else if (ld_op) begin
            d_r   <= B;
            dbz_r <= b_zero;
            if (b_zero) begin
                q_r <= {N{1'b1}};
                p_r <= {1'b0, A[M-1:0]};
            end else begin
                q_r <= A;
                p_r <= {(M + 1){1'b0}};
            end
        end else if (shift_en) begin
            q_r <= {q_r[N-2:0], ~sel_restore};
            p_r <= sel_restore ? p_shift_s : diff_s;
        end else begin
            q_r   <= q_r;
            p_r   <= p_r;
            d_r   <= d_r;
            dbz_r <= dbz_r;
        end
    end

    assign Q   = q_r;
    assign R   = p_r[M-1:0];
    assign dbz = dbz_r;

endmodule

// File: rtl/div8x4_seq.sv
// Sequential restoring unsigned divider (one quotient bit per clock) with a
// start/done handshake; datapath and control unit are separate blocks.
module div8x4_seq
    import div_pkg::*;
#(
    parameter int N = DIV_N,
    parameter int M = DIV_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [M-1:0] B,
    output logic [N-1:0] Q,
    output logic [M-1:0] R,
    output logic         dbz,
    output logic         busy,
    output logic         done
);

    logic ld_op;
    logic shift_en;
    logic sel_restore;
    logic b_zero;
    logic trial_ok;

    div8x4_cu #(.N(N)) u_cu (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .b_zero      (b_zero),
        .trial_ok    (trial_ok),
        .ld_op       (ld_op),
        .shift_en    (shift_en),
        .sel_restore (sel_restore),
        .busy        (busy),
        .done        (done)
    );

    div8x4_dp #(.N(N), .M(M)) u_dp (
        .clk         (clk),
        .rst         (rst),
        .ld_op       (ld_op),
        .shift_en    (shift_en),
        .sel_restore (sel_restore),
        .A           (A),
        .B           (B),
        .b_zero      (b_zero),
        .trial_ok    (trial_ok),
        .Q           (Q),
        .R           (R),
        .dbz         (dbz)
    );

endmodule
